idiv_seq: RTL
=============

Name: idiv_seq

Overview:
- Sequential unsigned integer divider, the inverse operation of the team's IMUL multipliers.
- Restoring division, one quotient bit per clock.
- Start/Busy/Done handshake for use alongside the multiplier datapath in the ALU lab designs.
- Produces quotient and remainder, and flags divide-by-zero.

Parameters:
SIZE, 4, operand width in bits (dividend, divisor, quotient, remainder); legal range 2..16.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset (0 = reset)
Start  input  1  request a division; sampled on rising edge
A  input  SIZE  dividend (unsigned)
B  input  SIZE  divisor (unsigned)
Busy  output  1  high while iterating (state CALC)
Done  output  1  one-cycle pulse: results valid/updated
DivByZero  output  1  high with Done when latched B was 0; held with results
Quotient  output  SIZE  A / B
Remainder  output  SIZE  A % B

Behaviour:
- Reset (Reset=0, asynchronous, any state) forces:
  - state IDLE;
  - Busy=0, Done=0, DivByZero=0;
  - Quotient=0, Remainder=0;
  - iteration counter=0.
  - An in-flight division is abandoned; no Done is produced for it.
- FSM states:
  - IDLE: Busy=0, Done=0. On Start=1:
    - latch A into the working quotient/dividend register and B into the divisor register; clear the partial remainder (SIZE+1 bits); counter=SIZE.
    - If B==0: go to DONE.
    - Otherwise go to CALC.
  - CALC: Busy=1. Each edge performs one restoring step:
    - T = {R[SIZE-1:0], Q[SIZE-1]} - {1'b0, D}.
    - If T[SIZE]==0: R=T, Q={Q[SIZE-2:0],1}.
    - Otherwise: R={R[SIZE-1:0], Q[SIZE-1]}, Q={Q[SIZE-2:0],0}.
    - Counter decrements.
    - On the step where the counter reaches 0: load Quotient=Q_next, Remainder=R_next[SIZE-1:0], DivByZero=0, and go to DONE.
  - DONE: Done=1 for exactly one cycle, Busy=0.
    - Start=1 here is accepted exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Divide-by-zero path (entering DONE directly from IDLE): Quotient={SIZE{1'b1}}, Remainder=A as latched, DivByZero=1.
- Latency:
  - B!=0: Start sampled at edge k; Done high in the cycle after edge k+SIZE, so Done is first seen SIZE+1 cycles after Start.
  - B==0: Done high in the cycle after edge k.
- Start during CALC is ignored; the latched operands are unaffected.
- Changes on A or B after the Start edge have no effect.
- Quotient, Remainder and DivByZero hold their values until the next result load or reset. They do not change during CALC.
- Arithmetic: all unsigned. The partial remainder is SIZE+1 bits wide so the subtraction sign bit is exact. Remainder < B always when B!=0.

Test Plan:
- SIZE=4, Reset=0 then released, Start=1 with A=13, B=3 → Busy high for 4 cycles; Done one-cycle pulse on the 5th cycle after Start; Quotient=4, Remainder=1, DivByZero=0.
- A=15, B=1 → Quotient=15, Remainder=0. A=3, B=9 → Quotient=0, Remainder=3. A=0, B=5 → Quotient=0, Remainder=0.
- A=7, B=0 → Done in the cycle after Start, Busy never high; Quotient=15, Remainder=7, DivByZero=1. A following 8/2 clears DivByZero, giving Quotient=4, Remainder=0.
- Start 14/4, then pulse Start with A=9, B=2 during cycle 2 of CALC → Quotient=3, Remainder=2; no second Done.
- Start 12/5, assert Reset=0 mid-CALC (between clock edges) → outputs immediately reset to 0, Busy=0; no Done after release; next 12/5 → Quotient=2, Remainder=2.
- Done for 6/4 with Start=1 and A=11, B=2 in the same cycle → Quotient=1/Remainder=2 shown during Done; Busy next cycle; then Quotient=5, Remainder=1.
- Exhaustive sweep, all A, B in 0..15 with B!=0 → Quotient/Remainder match a reference model, Done latency exactly 5 each time.

Source files
------------

// File: rtl/idiv_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock with a
// Start/Busy/Done handshake, quotient/remainder outputs and a divide-by-zero flag.
module idiv_seq #(
    parameter int SIZE = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Start,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    output logic            Busy,
    output logic            Done,
    output logic            DivByZero,
    output logic [SIZE-1:0] Quotient,
    output logic [SIZE-1:0] Remainder
);

    localparam int CNT_W = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [SIZE-1:0]   q_reg, q_nxt;
    logic [SIZE-1:0]   d_reg, d_nxt;
    logic [SIZE:0]     r_reg, r_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [SIZE-1:0]   quo_nxt, rem_nxt;
    logic              dz_nxt;
    logic [2*SIZE:0]   step;

    // One restoring iteration; returns {partial remainder, shifted quotient}.
    function automatic logic [2*SIZE:0] restore_step(
        input logic [SIZE:0]   r,
        input logic [SIZE-1:0] q,
        input logic [SIZE-1:0] d
    );
        logic [SIZE:0] sh;
        logic [SIZE:0] t;
        sh = {r[SIZE-1:0], q[SIZE-1]};
        t  = sh - {1'b0, d};
        if (!t[SIZE])
            return {t, q[SIZE-2:0], 1'b1};
        else
            return {sh, q[SIZE-2:0], 1'b0};
    endfunction

    assign step = restore_step(r_reg, q_reg, d_reg);
    assign Busy = (state == CALC);
    assign Done = (state == DONE);

    always_comb begin
        state_nxt = state;
        q_nxt     = q_reg;
        d_nxt     = d_reg;
        r_nxt     = r_reg;
        cnt_nxt   = cnt;
        quo_nxt   = Quotient;
        rem_nxt   = Remainder;
        dz_nxt    = DivByZero;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (Start) begin
                    q_nxt   = A;
                    d_nxt   = B;
                    r_nxt   = '0;
                    cnt_nxt = CNT_W'(SIZE);
                    if (B == '0) begin
                        // Zero divisor skips iteration and reports saturated quotient.
                        quo_nxt   = '1;
                        rem_nxt   = A;
                        dz_nxt    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                r_nxt   = step[2*SIZE:SIZE];
                q_nxt   = step[SIZE-1:0];
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    quo_nxt   = step[SIZE-1:0];
                    rem_nxt   = step[2*SIZE-1:SIZE];
                    dz_nxt    = 1'b0;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else begin
            state     <= state_nxt;
            q_reg     <= q_nxt;
            d_reg     <= d_nxt;
            r_reg     <= r_nxt;
            cnt       <= cnt_nxt;
            Quotient  <= quo_nxt;
            Remainder <= rem_nxt;
            DivByZero <= dz_nxt;
        end
    end

endmodule
